// File: rtl/rx_fifo_pop_ctrl_if.sv
// rx_fifo_pop_ctrl_if
//   Bundles the FIFO read-side handshake, the downstream valid/ready stream
//   and the status outputs of rx_fifo_pop_ctrl.
//   master : view of rx_fifo_pop_ctrl (drives pop, dout, status)
//   slave  : view of the environment (FIFO model / downstream / control)
// Signals
//   in_enable        global enable, 0 freezes the controller
//   fifo_canpop      FIFO holds at least one word
//   fifo_data_rd     FIFO head word (combinational from FIFO read pointer)
//   fifo_data_valid  FIFO canpop & (pop | forced drain), monitor only
//   fifo_dissync     FIFO forced-drain flag
//   fifo_pop_rd      pop request to the FIFO
//   dout/dout_valid  output word and its valid
//   dout_ready       downstream accepts dout
//   locked           controller is streaming (RUN)
//   dissync_cnt      saturating count of fifo_dissync rising edges
interface rx_fifo_pop_ctrl_if #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 16
);
  logic             in_enable;
  logic             fifo_canpop;
  logic [WIDTH-1:0] fifo_data_rd;
  logic             fifo_data_valid;
  logic             fifo_dissync;
  logic             fifo_pop_rd;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             locked;
  logic [CNT_W-1:0] dissync_cnt;

  modport master (
    input  in_enable, fifo_canpop, fifo_data_rd, fifo_data_valid,
           fifo_dissync, dout_ready,
    output fifo_pop_rd, dout, dout_valid, locked, dissync_cnt
  );

  modport slave (
    output in_enable, fifo_canpop, fifo_data_rd, fifo_data_valid,
           fifo_dissync, dout_ready,
    input  fifo_pop_rd, dout, dout_valid, locked, dissync_cnt
  );
endinterface

// File: rtl/rx_fifo_pop_ctrl.sv
// rx_fifo_pop_ctrl
//   Read-side consumer of the RX clock-crossing FIFO in the 25G PCS receive
//   path, running on the FIFO read clock. Pops the FIFO into a 2-entry skid
//   buffer, streams the buffer downstream over valid/ready, and runs a lock
//   FSM (INIT -> RUN -> RESYNC -> INIT) that waits for fill margin before
//   streaming and recovers after a FIFO dissync (forced drain).
// Ports
//   clk    FIFO read clock
//   reset  synchronous, active-high
//   bus    rx_fifo_pop_ctrl_if.master (FIFO side, stream side, status)
module rx_fifo_pop_ctrl #(
  parameter int WIDTH        = 48,
  parameter int START_CYCLES = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  rx_fifo_pop_ctrl_if.master bus
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_RESYNC = 2'd2;

  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_start_cnt;
  logic [7:0]       r_hold_cnt;

  // skid buffer: two entries, FIFO-ordered via read/write pointers
  logic [WIDTH-1:0] r_buf [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_cnt;

  logic             r_dissync_d;
  logic [CNT_W-1:0] r_dissync_cnt;

  logic w_en;
  logic w_run;
  logic w_pop;
  logic w_valid;
  logic w_xfer;
  logic w_flush;
  logic w_dis_rise;

  assign w_en    = bus.in_enable;
  assign w_run   = (r_state == S_RUN);
  // pop depends only on local state, never on dout_ready: the second buffer
  // entry absorbs the ready round trip
  assign w_pop   = w_en & w_run & bus.fifo_canpop & (r_cnt != 2'd2);
  assign w_valid = w_en & (r_cnt != 2'd0);
  assign w_xfer  = w_valid & bus.dout_ready;
  assign w_flush = w_run & bus.fifo_dissync;
  assign w_dis_rise = bus.fifo_dissync & ~r_dissync_d;

  assign bus.fifo_pop_rd = w_pop;
  assign bus.dout        = r_buf[r_rd_ptr];
  assign bus.dout_valid  = w_valid;
  assign bus.locked      = w_run;
  assign bus.dissync_cnt = r_dissync_cnt;

  // skid buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (w_en) begin
      if (w_flush) begin
        // flush wins over push/transfer; a transfer accepted this cycle has
        // already been taken downstream, nothing to undo
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_pop) begin
          r_buf[r_wr_ptr] <= bus.fifo_data_rd;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
        r_cnt <= r_cnt + {1'b0, w_pop} - {1'b0, w_xfer};
      end
    end
  end

  // lock FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_start_cnt <= 8'd0;
      r_hold_cnt  <= 8'd0;
    end else if (w_en) begin
      case (r_state)
        S_INIT: begin
          if (!bus.fifo_canpop) begin
            r_start_cnt <= 8'd0;
          end else if (r_start_cnt == START_LAST) begin
            r_start_cnt <= 8'd0;
            r_state     <= S_RUN;
          end else begin
            r_start_cnt <= r_start_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (bus.fifo_dissync) begin
            r_hold_cnt <= 8'd0;
            r_state    <= S_RESYNC;
          end
        end
        S_RESYNC: begin
          // a repeated dissync restarts the hold window
          if (bus.fifo_dissync) begin
            r_hold_cnt <= 8'd0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= 8'd0;
            r_state    <= S_INIT;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= S_INIT;
          r_start_cnt <= 8'd0;
          r_hold_cnt  <= 8'd0;
        end
      endcase
    end
  end

  // dissync event counter, independent of FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dissync_d   <= 1'b0;
      r_dissync_cnt <= '0;
    end else if (w_en) begin
      r_dissync_d <= bus.fifo_dissync;
      if (w_dis_rise && !(&r_dissync_cnt))
        r_dissync_cnt <= r_dissync_cnt + CNT_W'(1);
    end
  end

  // every pop must be seen by the FIFO as a valid read
  a_pop_has_data: assert property (@(posedge clk) disable iff (reset)
    w_pop |-> bus.fifo_data_valid);

endmodule

// File: tb/tb_rx_fifo_pop_ctrl.sv
module tb_rx_fifo_pop_ctrl;
  localparam int W     = 48;
  localparam int START = 4;
  localparam int HOLD  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rx_fifo_pop_ctrl_if #(.WIDTH(W), .CNT_W(16)) bus ();
  rx_fifo_pop_ctrl_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  rx_fifo_pop_ctrl #(.WIDTH(W), .START_CYCLES(START), .HOLD_CYCLES(HOLD),
                     .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));

  rx_fifo_pop_ctrl #(.WIDTH(W), .START_CYCLES(START), .HOLD_CYCLES(HOLD),
                     .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.master));

  // FIFO model: head word counts up on each pop
  logic [W-1:0] word;
  logic         drain;
  logic         adv;
  assign bus.fifo_data_rd     = word;
  assign bus.fifo_data_valid  = bus.fifo_canpop & (bus.fifo_pop_rd | drain);
  assign bus2.fifo_data_rd    = '0;
  assign bus2.fifo_data_valid = bus2.fifo_canpop & bus2.fifo_pop_rd;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] sbq [$];
  logic sb_flush;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // scoreboard: compare on transfer, push on pop (flush/reset discard)
  always @(negedge clk) begin
    if (bus.dout_valid && bus.dout_ready) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) chk("dout", 64'(bus.dout), 64'(sbq.pop_front()));
    end
    if (bus.fifo_pop_rd) adv = 1'b1;
    if (reset || sb_flush) sbq.delete();
    else if (bus.fifo_pop_rd) sbq.push_back(word);
  end

  always @(posedge clk) begin
    #1;
    if (adv) begin
      word = word + 1'b1;
      adv  = 1'b0;
    end
  end

  initial begin
    int first;
    int bad;
    logic [7:0] pat;
    word = 48'd1; drain = 1'b0; adv = 1'b0; sb_flush = 1'b0;
    bus.in_enable = 1'b1; bus.fifo_canpop = 1'b1; bus.fifo_dissync = 1'b0;
    bus.dout_ready = 1'b1;
    bus2.in_enable = 1'b1; bus2.fifo_canpop = 1'b0; bus2.fifo_dissync = 1'b0;
    bus2.dout_ready = 1'b1;

    // reset state
    reset = 1'b1;
    tick(); tick();
    smp();
    chk("rst_pop",    64'(bus.fifo_pop_rd), 64'd0);
    chk("rst_valid",  64'(bus.dout_valid),  64'd0);
    chk("rst_locked", 64'(bus.locked),      64'd0);
    chk("rst_dcnt",   64'(bus.dissync_cnt), 64'd0);
    chk("rst_dout",   64'(bus.dout),        64'd0);
    chk("rst_dcnt2",  64'(bus2.dissync_cnt), 64'd0);

    // startup: first pop in cycle START+1 after release
    tick(); reset = 1'b0;
    first = -1;
    for (int n = 1; n <= 40 && first < 0; n++) begin
      smp();
      if (bus.fifo_pop_rd) first = n;
    end
    chk("first_pop_cycle", 64'(first), 64'(START + 1));
    chk("start_locked", 64'(bus.locked), 64'd1);
    smp();
    chk("lat_valid", 64'(bus.dout_valid), 64'd1);
    chk("lat_dout",  64'(bus.dout), 64'd1);
    for (int n = 0; n < 8; n++) begin
      smp();
      chk("stream_valid", 64'(bus.dout_valid), 64'd1);
      chk("stream_pop",   64'(bus.fifo_pop_rd), 64'd1);
    end

    // backpressure: buffer fills, pop stops, then drains in order
    tick(); bus.dout_ready = 1'b0;
    repeat (6) smp();
    chk("bp_pop",   64'(bus.fifo_pop_rd), 64'd0);
    chk("bp_valid", 64'(bus.dout_valid),  64'd1);
    tick(); bus.dout_ready = 1'b1;
    repeat (10) smp();

    // enable freeze
    tick(); bus.in_enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      smp();
      chk("en0_pop",   64'(bus.fifo_pop_rd), 64'd0);
      chk("en0_valid", 64'(bus.dout_valid),  64'd0);
    end
    tick(); bus.in_enable = 1'b1;
    smp();
    chk("en1_locked", 64'(bus.locked), 64'd1);
    chk("en1_valid",  64'(bus.dout_valid), 64'd1);
    repeat (6) smp();

    // dissync with a full buffer
    tick(); bus.dout_ready = 1'b0;
    repeat (3) smp();
    chk("full_pop", 64'(bus.fifo_pop_rd), 64'd0);
    tick(); bus.fifo_dissync = 1'b1; sb_flush = 1'b1;
    smp();
    tick(); bus.fifo_dissync = 1'b0; sb_flush = 1'b0; bus.dout_ready = 1'b1; drain = 1'b1;
    smp();
    chk("dis_valid",  64'(bus.dout_valid),  64'd0);
    chk("dis_locked", 64'(bus.locked),      64'd0);
    chk("dis_cnt",    64'(bus.dissync_cnt), 64'd1);
    // RESYNC + INIT: forced-drain words must never be captured
    first = -1; bad = 0;
    for (int n = 1; n <= 60 && first < 0; n++) begin
      smp();
      if (bus.dout_valid) bad++;
      if (bus.fifo_pop_rd) first = n;
    end
    drain = 1'b0;
    chk("resync_relock_cycle", 64'(first), 64'(HOLD + START));
    chk("resync_no_valid",     64'(bad),   64'd0);
    repeat (5) smp();
    chk("dis_cnt_kept", 64'(bus.dissync_cnt), 64'd1);

    // mid-stream reset, then INIT canpop pattern 1,1,1,0,1,1,1,1
    tick(); reset = 1'b1;
    pat = 8'b1111_0111;  // bit i = cycle i
    tick(); reset = 1'b0; bus.fifo_canpop = pat[0];
    smp();
    chk("mrst_dcnt", 64'(bus.dissync_cnt), 64'd0);
    bad = (bus.fifo_pop_rd || bus.locked) ? 1 : 0;
    for (int i = 1; i < 8; i++) begin
      tick(); bus.fifo_canpop = pat[i];
      smp();
      if (bus.fifo_pop_rd || bus.locked) bad++;
    end
    chk("init_no_pop", 64'(bad), 64'd0);
    tick(); bus.fifo_canpop = 1'b1;
    smp();
    chk("init_run_pop",    64'(bus.fifo_pop_rd), 64'd1);
    chk("init_run_locked", 64'(bus.locked),      64'd1);
    repeat (4) smp();

    // canpop falls in RUN: drain, stay locked
    tick(); bus.fifo_canpop = 1'b0;
    repeat (3) smp();
    chk("underrun_valid",  64'(bus.dout_valid), 64'd0);
    chk("underrun_locked", 64'(bus.locked),     64'd1);

    // saturation of the 2-bit counter
    for (int p = 1; p <= 5; p++) begin
      tick(); bus2.fifo_dissync = 1'b1;
      tick(); bus2.fifo_dissync = 1'b0;
      smp();
      chk("sat_cnt", 64'(bus2.dissync_cnt), 64'((p < 3) ? p : 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
